// File: rtl/decode_queue.sv
// decode_queue: decodes RV32I integer ALU instructions (OP-IMM, OP, LUI, AUIPC)
// at the fetch boundary and buffers the decoded records in a DEPTH-entry FIFO.
//
// Ports
//   clk_i, rst_i          clock and synchronous active-high reset
//   flush_i               drop every buffered entry
//   valid_i/ready_o       fetch-side handshake; pc_i, instr_i the instruction
//   valid_o/ready_i       issue-side handshake
//   instr_decoded_o       decoded head entry; illegal_o marks an illegal encoding
//   illegal_cnt_o         saturating count of accepted illegal instructions
//                         (only built when DECODE_ILLEGAL_CNT_EN is defined)
//
// Optional feature macro: DECODE_ILLEGAL_CNT_EN

package decode_queue_pkg;

    typedef logic [31:0] bus32_t;
    typedef logic [31:0] instruction_t;

    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Operand selects; the zero encodings are the "neutral" values used for illegal entries
    localparam logic SEL_RS1 = 1'b0;
    localparam logic SEL_PC  = 1'b1;
    localparam logic SEL_RS2 = 1'b0;
    localparam logic SEL_IMM = 1'b1;
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

    typedef struct packed {
        bus32_t       pc;
        instruction_t instr;
        logic [4:0]   addr_rs1;
        logic [4:0]   addr_rs2;
        logic [4:0]   addr_rd;
        logic [31:0]  imm;
        logic [3:0]   alu_op;
        logic         rs1_or_pc;
        logic         rs2_or_imm;
        logic         alu_or_mem;
        logic         store_to_mem;
        logic         write_enable;
    } instr_data_t;

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  bus32_t             pc_i,
    input  instruction_t       instr_i,
    output logic               valid_o,
    input  logic               ready_i,
    output instr_data_t        instr_decoded_o,
    output logic               illegal_o
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0]   illegal_cnt_o
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > 8 || CNT_W < 1) begin : g_bad_param
        $error("decode_queue: DEPTH must be 1..8 and CNT_W at least 1");
    end

    instr_data_t      r_mem [DEPTH];
    logic             r_ill [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_count;

    instr_data_t      w_dec;
    logic             w_ill;
    logic             w_push;
    logic             w_pop;
    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];

    // Input-side decoder
    always_comb begin
        w_dec       = '0;
        w_dec.pc    = pc_i;
        w_dec.instr = instr_i;
        w_ill       = 1'b0;
        case (w_opcode)
            OP_ALU_I: begin
                w_dec.addr_rs1     = instr_i[19:15];
                w_dec.addr_rd      = instr_i[11:7];
                w_dec.rs2_or_imm   = SEL_IMM;
                w_dec.write_enable = 1'b1;
                w_dec.imm          = {{20{instr_i[31]}}, instr_i[31:20]};
                case (w_f3)
                    3'b000: w_dec.alu_op = ALU_ADD;
                    3'b010: w_dec.alu_op = ALU_SLT;
                    3'b011: w_dec.alu_op = ALU_SLTU;
                    3'b100: w_dec.alu_op = ALU_XOR;
                    3'b110: w_dec.alu_op = ALU_OR;
                    3'b111: w_dec.alu_op = ALU_AND;
                    3'b001: begin
                        w_dec.alu_op = ALU_SLL;
                        w_dec.imm    = 32'(instr_i[24:20]);
                        w_ill        = (w_f7 != 7'h00);
                    end
                    default: begin
                        // funct3 101: funct7 selects logical vs arithmetic shift
                        w_dec.imm = 32'(instr_i[24:20]);
                        if (w_f7 == 7'h00)      w_dec.alu_op = ALU_SRL;
                        else if (w_f7 == 7'h20) w_dec.alu_op = ALU_SRA;
                        else                    w_ill = 1'b1;
                    end
                endcase
            end
            OP_ALU: begin
                w_dec.addr_rs1     = instr_i[19:15];
                w_dec.addr_rs2     = instr_i[24:20];
                w_dec.addr_rd      = instr_i[11:7];
                w_dec.rs2_or_imm   = SEL_RS2;
                w_dec.write_enable = 1'b1;
                case (w_f3)
                    3'b000:  w_dec.alu_op = (w_f7 == 7'h20) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_dec.alu_op = ALU_SLL;
                    3'b010:  w_dec.alu_op = ALU_SLT;
                    3'b011:  w_dec.alu_op = ALU_SLTU;
                    3'b100:  w_dec.alu_op = ALU_XOR;
                    3'b101:  w_dec.alu_op = (w_f7 == 7'h20) ? ALU_SRA : ALU_SRL;
                    3'b110:  w_dec.alu_op = ALU_OR;
                    default: w_dec.alu_op = ALU_AND;
                endcase
                // Only ADD/SUB and SRL/SRA have a 0x20 variant
                if (w_f7 == 7'h20) w_ill = !(w_f3 == 3'b000 || w_f3 == 3'b101);
                else               w_ill = (w_f7 != 7'h00);
            end
            OP_LUI: begin
                w_dec.addr_rd      = instr_i[11:7];
                w_dec.rs1_or_pc    = SEL_RS1;
                w_dec.rs2_or_imm   = SEL_IMM;
                w_dec.imm          = {instr_i[31:12], 12'h000};
                w_dec.alu_op       = ALU_ADD;
                w_dec.write_enable = 1'b1;
            end
            OP_AUIPC: begin
                w_dec.addr_rd      = instr_i[11:7];
                w_dec.rs1_or_pc    = SEL_PC;
                w_dec.rs2_or_imm   = SEL_IMM;
                w_dec.imm          = {instr_i[31:12], 12'h000};
                w_dec.alu_op       = ALU_ADD;
                w_dec.write_enable = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        // Illegal entries collapse to a harmless no-write ADD, keeping pc/instr for traps
        if (w_ill) begin
            w_dec       = '0;
            w_dec.pc    = pc_i;
            w_dec.instr = instr_i;
        end
    end

    assign ready_o = (r_count < OCC_W'(DEPTH));
    assign valid_o = (r_count != '0);
    assign w_push  = valid_i && ready_o;
    assign w_pop   = valid_o && ready_i;

    // Head is read from storage only; zero when empty
    assign instr_decoded_o = valid_o ? r_mem[r_rd_ptr] : '0;
    assign illegal_o       = valid_o && r_ill[r_rd_ptr];

    // Entry storage, written on an accepted push
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i && !rst_i) begin
            r_mem[r_wr_ptr] <= w_dec;
            r_ill[r_wr_ptr] <= w_ill;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DECODE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] r_ill_cnt;

    // Saturating illegal-instruction counter; survives flush
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ill_cnt <= '0;
        end else if (w_push && !flush_i && w_ill && (r_ill_cnt != '1)) begin
            r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign illegal_cnt_o = r_ill_cnt;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=2). Inputs change 1ns after the rising
// edge; outputs are sampled in the same window.

module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    bus32_t       pc_i;
    instruction_t instr_i;
    logic         valid_o;
    logic         ready_i;
    instr_data_t  instr_decoded_o;
    logic         illegal_o;
`ifdef DECODE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .pc_i            (pc_i),
        .instr_i         (instr_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .instr_decoded_o (instr_decoded_o),
        .illegal_o       (illegal_o)
`ifdef DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt_o   (illegal_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input bus32_t pc, input instruction_t ins);
        valid_i = v;
        pc_i    = pc;
        instr_i = ins;
    endtask

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst_i = 1'b0;

        // Post-reset state
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_illegal", illegal_o, 1'b0);
        check("rst_decoded", instr_decoded_o, '0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("rst_cnt", illegal_cnt_o, '0);
`endif

        // ADDI x1,x0,5 at 0x100
        drive(1'b1, 32'h100, 32'h00500093);
        #1;
        check("addi_no_comb_path", valid_o, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("addi_valid", valid_o, 1'b1);
        check("addi_op", instr_decoded_o.alu_op, ALU_ADD);
        check("addi_imm_sel", instr_decoded_o.rs2_or_imm, SEL_IMM);
        check("addi_imm", instr_decoded_o.imm, 32'd5);
        check("addi_rd", instr_decoded_o.addr_rd, 5'd1);
        check("addi_rs1", instr_decoded_o.addr_rs1, 5'd0);
        check("addi_we", instr_decoded_o.write_enable, 1'b1);
        check("addi_pc", instr_decoded_o.pc, 32'h100);
        check("addi_illegal", illegal_o, 1'b0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("addi_popped", valid_o, 1'b0);

        // Backpressure: A=ADDI x2,x1,3  B=XORI x3,x2,-1  C=ORI x4,x0,0x7f
        drive(1'b1, 32'h200, 32'h00308113);
        tick();
        check("bp_ready_1", ready_o, 1'b1);
        drive(1'b1, 32'h204, 32'hFFF14193);
        tick();
        check("bp_ready_full", ready_o, 1'b0);
        drive(1'b1, 32'h208, 32'h07F06213);
        tick();
        check("bp_ready_held", ready_o, 1'b0);
        check("bp_head_pc", instr_decoded_o.pc, 32'h200);
        check("bp_head_instr", instr_decoded_o.instr, 32'h00308113);
        check("bp_head_rd", instr_decoded_o.addr_rd, 5'd2);
        ready_i = 1'b1;
        tick();
        check("bp_b_pc", instr_decoded_o.pc, 32'h204);
        check("bp_b_op", instr_decoded_o.alu_op, ALU_XOR);
        check("bp_b_imm", instr_decoded_o.imm, 32'hFFFFFFFF);
        check("bp_ready_after_pop", ready_o, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("bp_c_pc", instr_decoded_o.pc, 32'h208);
        check("bp_c_op", instr_decoded_o.alu_op, ALU_OR);
        check("bp_c_rd", instr_decoded_o.addr_rd, 5'd4);
        check("bp_c_imm", instr_decoded_o.imm, 32'h7F);
        tick();
        ready_i = 1'b0;
        check("bp_drained", valid_o, 1'b0);

        // Illegal encodings: all-ones, then OP with funct7=0x01
        drive(1'b1, 32'h300, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 32'h304, 32'h022082B3);
        check("ill_flag", illegal_o, 1'b1);
        check("ill_we", instr_decoded_o.write_enable, 1'b0);
        check("ill_rd", instr_decoded_o.addr_rd, 5'd0);
        check("ill_rs1", instr_decoded_o.addr_rs1, 5'd0);
        check("ill_instr", instr_decoded_o.instr, 32'hFFFFFFFF);
        check("ill_pc", instr_decoded_o.pc, 32'h300);
        check("ill_imm_sel", instr_decoded_o.rs2_or_imm, SEL_RS2);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("ill_cnt_1", illegal_cnt_o, 16'd1);
`endif
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("ill_full", ready_o, 1'b0);
        check("ill_head_stable", instr_decoded_o.pc, 32'h300);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("ill_f7_flag", illegal_o, 1'b1);
        check("ill_f7_rd", instr_decoded_o.addr_rd, 5'd0);
        check("ill_f7_rs2", instr_decoded_o.addr_rs2, 5'd0);
        check("ill_f7_instr", instr_decoded_o.instr, 32'h022082B3);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("ill_cnt_2", illegal_cnt_o, 16'd2);
`endif

        // Refill to full, then flush with a presented instruction
        drive(1'b1, 32'h400, 32'h00500093);
        tick();
        check("fl_full", ready_o, 1'b0);
        flush_i = 1'b1;
        drive(1'b1, 32'h404, 32'h00500093);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_valid", valid_o, 1'b0);
        check("fl_ready", ready_o, 1'b1);
        tick();
        check("fl_not_enq", valid_o, 1'b0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("fl_cnt_kept", illegal_cnt_o, 16'd2);
`endif
        // Flush overrides a same-cycle push and pop with room available
        drive(1'b1, 32'h500, 32'h00500093);
        tick();
        flush_i = 1'b1;
        ready_i = 1'b1;
        drive(1'b1, 32'h504, 32'hFFFFFFFF);
        tick();
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl2_valid", valid_o, 1'b0);
        tick();
        check("fl2_not_enq", valid_o, 1'b0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("fl2_cnt", illegal_cnt_o, 16'd2);
`endif

        // Streaming: SUB x7,x5,x6 / AUIPC x8,0x12345 alternating, one output per cycle
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) drive(1'b1, 32'h1000 + 32'(4 * i), 32'h406283B3);
            else            drive(1'b1, 32'h1000 + 32'(4 * i), 32'h12345417);
            tick();
            check("st_valid", valid_o, 1'b1);
            check("st_ready", ready_o, 1'b1);
            check("st_pc", instr_decoded_o.pc, 32'h1000 + 32'(4 * i));
            if (i % 2 == 0) begin
                check("st_sub_op", instr_decoded_o.alu_op, ALU_SUB);
                check("st_sub_rs2", instr_decoded_o.addr_rs2, 5'd6);
                check("st_sub_sel", instr_decoded_o.rs2_or_imm, SEL_RS2);
            end else begin
                check("st_auipc_op", instr_decoded_o.alu_op, ALU_ADD);
                check("st_auipc_pcsel", instr_decoded_o.rs1_or_pc, SEL_PC);
                check("st_auipc_imm", instr_decoded_o.imm, 32'h12345000);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        ready_i = 1'b0;
        check("st_drained", valid_o, 1'b0);

        // LUI x9,0xABCDE and SRAI x10,x1,3, then reset mid-operation
        drive(1'b1, 32'h600, 32'hABCDE4B7);
        tick();
        check("lui_rs1", instr_decoded_o.addr_rs1, 5'd0);
        check("lui_imm", instr_decoded_o.imm, 32'hABCDE000);
        check("lui_sel", instr_decoded_o.rs1_or_pc, SEL_RS1);
        check("lui_rd", instr_decoded_o.addr_rd, 5'd9);
        drive(1'b1, 32'h604, 32'h4030D513);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("srai_op", instr_decoded_o.alu_op, ALU_SRA);
        check("srai_imm", instr_decoded_o.imm, 32'd3);
        check("srai_rs1", instr_decoded_o.addr_rs1, 5'd1);
        rst_i = 1'b1;
        drive(1'b1, 32'h608, 32'h00500093);
        tick();
        rst_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("mrst_valid", valid_o, 1'b0);
        check("mrst_ready", ready_o, 1'b1);
        check("mrst_illegal", illegal_o, 1'b0);
`ifdef DECODE_ILLEGAL_CNT_EN
        check("mrst_cnt", illegal_cnt_o, '0);
`endif
        tick();
        check("mrst_no_reappear", valid_o, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
- REQ-001 The block SHALL have parameter DEPTH, default 2, meaning number of decoded-instruction buffer entries (legal range 1..8).
- REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the illegal-instruction counter.
- REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 The block SHALL have port rst_i, input, 1, synchronous active-high reset.
- REQ-005 The block SHALL have port flush_i, input, 1, discard all buffered entries.
- REQ-006 The block SHALL have port valid_i, input, 1, fetch presents an instruction.
- REQ-007 The block SHALL have port ready_o, output, 1, queue can accept an instruction this cycle.
- REQ-008 The block SHALL have port pc_i, input, bus32_t, PC of the presented instruction.
- REQ-009 The block SHALL have port instr_i, input, instruction_t, raw instruction word.
- REQ-010 The block SHALL have port valid_o, output, 1, head entry is valid.
- REQ-011 The block SHALL have port ready_i, input, 1, downstream consumes the head entry.
- REQ-012 The block SHALL have port instr_decoded_o, output, instr_data_t, decoded head entry.
- REQ-013 The block SHALL have port illegal_o, output, 1, head entry came from an illegal encoding.
- REQ-014 The block SHALL have port illegal_cnt_o, output, CNT_W, number of illegal instructions accepted (present only under the macro in REQ-031).

Function
- REQ-015 The block SHALL decode each instruction combinationally at the input and store the result in a DEPTH-entry circular buffer with read pointer, write pointer and occupancy count.
- REQ-016 The block SHALL decode OP_ALU_I with funct3 ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI to ADD/SLT/SLTU/XOR/OR/AND/SLL/SRL/SRA, rs2_or_imm=IMM, rs1_or_pc=RS1, write_enable=1.
- REQ-017 The block SHALL decode OP_ALU with funct3/funct7 to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND, rs2_or_imm=RS2, write_enable=1; funct7 other than 0x00 (or 0x20 for SUB/SRA) is illegal.
- REQ-018 The block SHALL decode OP_LUI as addr_rs1=0, IMM, ADD, and OP_AUIPC as rs1_or_pc=PC, IMM, ADD, both with write_enable=1.
- REQ-019 The block SHALL encode every illegal instruction as write_enable=0, addr_rs1/addr_rs2/addr_rd=0, RS1, RS2, ADD, ALU, store_to_mem=0, with the entry's illegal bit set; pc and instr fields are kept unmodified.
- REQ-020 The block SHALL set alu_or_mem=ALU and store_to_mem=0 for all legal instructions in this block.
- REQ-021 The block SHALL drive ready_o = 1 exactly when occupancy < DEPTH; a push occurs when valid_i && ready_o.
- REQ-022 The block SHALL drive valid_o = 1 exactly when occupancy > 0; a pop occurs when valid_o && ready_i.
- REQ-023 The block SHALL present a pushed instruction on instr_decoded_o no earlier than the cycle after the push (one-cycle minimum latency, no input-to-output combinational path).
- REQ-024 The block SHALL support simultaneous push and pop in one cycle, occupancy unchanged; a full queue does not accept in the cycle it pops.
- REQ-025 The block SHALL wrap both pointers from DEPTH-1 to 0.
- REQ-026 The block SHALL, on flush_i, reset occupancy and pointers to 0 in the next cycle; flush_i overrides a same-cycle push and pop, and ready_o is not gated by flush_i.
- REQ-027 The block SHALL hold instr_decoded_o and illegal_o stable while valid_o=1 and ready_i=0.

Reset
- REQ-028 The block SHALL, when rst_i=1 at a clock edge, clear occupancy, pointers and counter to 0; rst_i overrides flush_i, push and pop.
- REQ-029 The block SHALL, after reset, drive valid_o=0, ready_o=1, illegal_o=0, illegal_cnt_o=0, and instr_decoded_o all-zero.
- REQ-030 The block SHALL discard entries in flight when reset asserts mid-operation; none reappear after deassertion.

Configuration
- REQ-031 With macro DECODE_ILLEGAL_CNT_EN defined, the block SHALL increment illegal_cnt_o on each push of an illegal instruction, saturating at 2^CNT_W-1, unaffected by flush_i; without it, illegal_cnt_o and the counter SHALL not exist.

Verification
- REQ-032 Bench: reset, push ADDI x1,x0,5 (0x00500093) at PC 0x100 -> next cycle valid_o=1, alu_op=ADD, IMM, addr_rd=1, write_enable=1, illegal_o=0.
- REQ-033 Bench: DEPTH=2, ready_i=0, push 3 instructions -> ready_o=0 after second push, third held, head unchanged; then ready_i=1 -> FIFO order preserved.
- REQ-034 Bench: push 0xFFFFFFFF -> illegal_o=1, write_enable=0, addr_rd=0; with DECODE_ILLEGAL_CNT_EN illegal_cnt_o=1.
- REQ-035 Bench: queue full, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, flushed instruction not enqueued.
- REQ-036 Bench: continuous valid_i=1/ready_i=1 over 20 cycles with SUB (funct7 0x20) and AUIPC -> one output per cycle, SUB and PC/IMM decoded, pointers wrap correctly.
